// File: rtl/calc_pkg.sv
// calc_pkg: shared constants, types and helpers for the calculator mode controller.
// Provides MODE_IDLE, default IR codes, power-state enum and mode-width function.
package calc_pkg;

  localparam int MODE_IDLE = 0;

  localparam logic [31:0] IR_MODE_MASK_DEF = 32'hFFFF_0000;
  localparam logic [31:0] IR_PWR_CODE_DEF  = 32'h1BE4_FD02;

  // Mode 1 in the low word, mode 3 in the high word.
  localparam logic [95:0] IR_MODE_CODES_DEF = {
    32'h8E71_0000,
    32'h36C9_0000,
    32'h16E9_0000
  };

  typedef enum logic {
    PWR_OFF = 1'b0,
    PWR_ON  = 1'b1
  } pwr_e;

  function automatic int mode_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus DEB_CYCLES stability filter for an active-low button.
// Ports: clk_i, rst_i (async high), btn_ni (raw button), rel_o (one-cycle pulse on debounced release).
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic rel_o
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          meta_q;
  logic          sync_q;
  logic          deb_q;
  logic          deb_d;
  logic          rel_q;
  logic          rel_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter tracks consecutive samples disagreeing with the debounced level.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    rel_d = 1'b0;
    if (sync_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d = sync_q;
        rel_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      deb_q  <= 1'b1;
      rel_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= btn_ni;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      rel_q  <= rel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rel_o = rel_q;

endmodule

// File: rtl/calc_mode_ctrl.sv
// calc_mode_ctrl: merges N mode buttons, a power button and IR frames into power/mode state.
// Ports: CLK, RST, BTN_MODE, BTN_PWR, IR_VALID, IR_DATA -> POWER, MODE, MODE_ONEHOT, EVT. Option: CALC_AUTO_OFF_EN.
module calc_mode_ctrl
  import calc_pkg::*;
#(
  parameter int                         NUM_MODES     = 3,
  parameter int                         DEB_CYCLES    = 16,
  parameter int                         IR_W          = 32,
  parameter logic [IR_W-1:0]            IR_MODE_MASK  = IR_MODE_MASK_DEF,
  parameter logic [NUM_MODES*IR_W-1:0]  IR_MODE_CODES = IR_MODE_CODES_DEF,
  parameter logic [IR_W-1:0]            IR_PWR_CODE   = IR_PWR_CODE_DEF,
  parameter int                         IDLE_CYCLES   = 2**24
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_MODES-1:0]             BTN_MODE,
  input  logic                             BTN_PWR,
  input  logic                             IR_VALID,
  input  logic [IR_W-1:0]                  IR_DATA,
  output logic                             POWER,
  output logic [mode_w(NUM_MODES)-1:0]     MODE,
  output logic [NUM_MODES-1:0]             MODE_ONEHOT,
  output logic                             EVT
);

  localparam int MW = mode_w(NUM_MODES);

  logic [NUM_MODES:0]   btn_n;
  logic [NUM_MODES:0]   btn_rel;
  logic [NUM_MODES-1:0] ir_mode;
  logic [NUM_MODES-1:0] mode_ev;
  logic                 ir_pwr;
  logic                 pwr_ev;
  logic                 sel_hit;
  logic [MW-1:0]        sel_idx;
  logic                 accept;

  pwr_e          pwr_q;
  pwr_e          pwr_d;
  logic [MW-1:0] mode_q;
  logic [MW-1:0] mode_d;
  logic          evt_q;
  logic          evt_d;

  assign btn_n = {BTN_PWR, BTN_MODE};

  for (genvar g = 0; g <= NUM_MODES; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk_i (CLK),
      .rst_i (RST),
      .btn_ni(btn_n[g]),
      .rel_o (btn_rel[g])
    );
  end

  // A frame matching the power code never counts as a mode frame.
  always_comb begin
    ir_pwr = IR_VALID && (IR_DATA == IR_PWR_CODE);
    for (int k = 0; k < NUM_MODES; k++) begin
      ir_mode[k] = IR_VALID && !ir_pwr &&
        ((IR_DATA & IR_MODE_MASK) ==
         (IR_MODE_CODES[k*IR_W +: IR_W] & IR_MODE_MASK));
    end
    mode_ev = btn_rel[NUM_MODES-1:0] | ir_mode;
    pwr_ev  = btn_rel[NUM_MODES] | ir_pwr;
  end

  // Scan downwards so the lowest index ends up selected.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int k = NUM_MODES - 1; k >= 0; k--) begin
      if (mode_ev[k]) begin
        sel_hit = 1'b1;
        sel_idx = MW'(k + 1);
      end
    end
  end

  assign accept = pwr_ev || (sel_hit && (pwr_q == PWR_ON));

`ifdef CALC_AUTO_OFF_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_d;
  logic          idle_to;

  assign idle_to = (pwr_q == PWR_ON) &&
                   (idle_q == IW'(IDLE_CYCLES - 1));

  always_comb begin
    idle_d = '0;
    if ((pwr_q == PWR_ON) && !accept && !idle_to) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic idle_to;
  logic unused_idle;

  assign idle_to     = 1'b0;
  assign unused_idle = ^IDLE_CYCLES;
`endif

  always_comb begin
    pwr_d  = pwr_q;
    mode_d = mode_q;
    if (pwr_ev) begin
      pwr_d  = (pwr_q == PWR_ON) ? PWR_OFF : PWR_ON;
      mode_d = MW'(MODE_IDLE);
    end else if (sel_hit && (pwr_q == PWR_ON)) begin
      mode_d = (mode_q == sel_idx) ? MW'(MODE_IDLE) : sel_idx;
    end else if (idle_to) begin
      pwr_d  = PWR_OFF;
      mode_d = MW'(MODE_IDLE);
    end
    evt_d = (pwr_d != pwr_q) || (mode_d != mode_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwr_q  <= PWR_OFF;
      mode_q <= MW'(MODE_IDLE);
      evt_q  <= 1'b0;
    end else begin
      pwr_q  <= pwr_d;
      mode_q <= mode_d;
      evt_q  <= evt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_MODES; k++) begin
      MODE_ONEHOT[k] = (mode_q == MW'(k + 1));
    end
  end

  assign POWER = (pwr_q == PWR_ON);
  assign MODE  = mode_q;
  assign EVT   = evt_q;

endmodule

// File: doc/calc_mode_ctrl.md
Name: calc_mode_ctrl

Overview:
Parametrised operating-mode controller for the calculator front end. It merges N debounced active-low mode buttons, one power button and decoded IR remote frames into a single power/mode state. It drives the result selector and display path. It replaces the fixed three-mode button/IR logic with a generic N-mode, debounced, priority-resolved version.

Parameters:
NUM_MODES, 3, number of arithmetic modes (mode k = 1..NUM_MODES; 0 = ON/idle)
DEB_CYCLES, 16, cycles a synchronised button level must hold before the debounced level changes (>=2)
IR_W, 32, IR frame width
IR_MODE_MASK, 32'hFFFF_0000, bits compared for mode codes
IR_MODE_CODES, {16'h16e9,16'h36c9,16'h8e71} in upper halves, flattened NUM_MODES*IR_W; entry k-1 at bits [k*IR_W-1:(k-1)*IR_W]
IR_PWR_CODE, 32'h1BE4_FD02, power code, full-width compare
IDLE_CYCLES, 2**24, auto-off timeout (used only with CALC_AUTO_OFF_EN)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
BTN_MODE  in  NUM_MODES  mode buttons, active-low, asynchronous to CLK
BTN_PWR  in  1  power button, active-low, asynchronous
IR_VALID  in  1  one-cycle strobe: IR_DATA holds a complete frame
IR_DATA  in  IR_W  decoded IR frame
POWER  out  1  1 = calculator on
MODE  out  $clog2(NUM_MODES+1)  0 = idle/off, k = mode k
MODE_ONEHOT  out  NUM_MODES  bit k-1 set iff MODE==k
EVT  out  1  one-cycle pulse when POWER or MODE changed this cycle

Behaviour:
- Reset (async assert, sync-released use): POWER=0, MODE=0, MODE_ONEHOT=0, EVT=0, debouncers at released level (1), counters 0.
- Buttons: 2-FF synchroniser. Debounced level follows the synced level only after DEB_CYCLES consecutive equal samples. Button event = debounced 0->1 transition (release). One event per press.
- IR: on IR_VALID, mode-k event iff (IR_DATA & IR_MODE_MASK) == (code_k & IR_MODE_MASK). Power event iff IR_DATA == IR_PWR_CODE (full width). Power match takes precedence over mode match for the same frame.
- Arbitration per cycle: any power event (button or IR) wins. Otherwise the lowest-index mode event wins. All other events that cycle are discarded.
- Transitions, applied at the clock edge after the event cycle (1-cycle latency from event to outputs):
  - OFF (POWER=0) + power -> POWER=1, MODE=0.
  - OFF + mode event -> ignored.
  - ON + power -> POWER=0, MODE=0 (clears mode).
  - ON, MODE==k + mode k -> MODE=0 (toggle off).
  - ON, MODE!=k + mode k -> MODE=k (direct switch, no pass through 0).
- EVT pulses only when POWER or MODE actually changes. Ignored events give no pulse.
- Button held through RST deassertion: no event until a real release after debounce.
- Reset mid-debounce discards the partial count.

Optional Feature:
CALC_AUTO_OFF_EN: when defined, an idle counter clears on every accepted event and increments while POWER=1. At IDLE_CYCLES: POWER=0, MODE=0, EVT=1. A real event in the same cycle takes precedence and resets the counter. When undefined: no counter; power changes only via power events.

Decomposition:
- Package calc_pkg: MODE_IDLE=0 constant, default IR code constants, mode width function.
- One sub-module, btn_debounce (synchroniser + DEB_CYCLES counter + release-pulse output), instantiated NUM_MODES+1 times.
- Arbitration and state register inline.

Test Plan:
- Setup for all: NUM_MODES=3, DEB_CYCLES=4.
- Power via button: BTN_PWR low 10 cycles then high -> POWER=1, MODE=0, one EVT pulse ~7 cycles after release. Repeat with MODE=2 set -> POWER=0, MODE=0.
- Mode toggle and switch: powered on, release BTN_MODE[1] -> MODE=2, MODE_ONEHOT=3'b010. Release BTN_MODE[1] again -> MODE=0. Release BTN_MODE[2] then BTN_MODE[0] -> MODE=3, then MODE=1.
- Bounce: BTN_MODE[0] toggling every 2 cycles for 20 cycles, then stable high -> exactly one event, MODE=1.
- IR: IR_VALID with IR_DATA=32'h36c9_1234 -> MODE=2. IR_DATA=32'h1BE4_FD02 -> POWER=0. IR_DATA=32'h1BE4_FD03 -> no change, EVT=0.
- Simultaneous and off: power off, release BTN_MODE[0] -> ignored. Powered on, same-cycle BTN_MODE[2] release and IR mode-1 frame -> MODE=1. Same-cycle power event and mode event -> power toggles, mode event dropped.
- Auto-off (macro on, IDLE_CYCLES=100): power on, no events -> POWER=0 and EVT at cycle 100. Event at cycle 99 restarts the count.
